// File: rtl/commit_stage_pkg.sv
// commit_stage_pkg
// Purpose: shared types for the retire side of the pipeline: the ROB commit
//          packet layout, free-list and branch-predictor training packets,
//          the architectural map type and the sizing constants they use.
// Contents:
//   N            retire width (matches ROB commit slots)
//   ARCH_REG_SZ  architectural register count; arn 0 is never mapped
//   PRN_WIDTH    physical register number width
//   identity_map reset value of the architectural map (arch_map[a] = a)
package commit_stage_pkg;

  localparam int N           = 4;
  localparam int ARCH_REG_SZ = 32;
  localparam int PRN_WIDTH   = 6;
  localparam int ARN_WIDTH   = $clog2(ARCH_REG_SZ);
  localparam int CNT_W       = $clog2(N + 1);

  typedef logic [PRN_WIDTH-1:0] prn_t;
  typedef logic [ARN_WIDTH-1:0] arn_t;

  typedef struct packed {
    logic        executed;
    logic        success;
    arn_t        dest_arn;
    prn_t        dest_prn;
    logic        is_store;
    logic        cond_branch;
    logic        uncond_branch;
    logic        halt;
    logic        illegal;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic [31:0] pc;
    logic [31:0] npc;
  } ROB_ENTRY;

  typedef struct packed {
    ROB_ENTRY [N-1:0] entries;
  } ROB_CT_PACKET;

  typedef struct packed {
    logic valid;
    prn_t prn;
  } fl_slot_t;

  typedef struct packed {
    fl_slot_t [N-1:0] slot;
  } CT_FL_PACKET;

  typedef struct packed {
    logic        valid;
    logic        cond;
    logic        taken;
    logic [31:0] pc;
    logic [31:0] target;
  } bp_slot_t;

  typedef struct packed {
    bp_slot_t [N-1:0] slot;
  } CT_BP_PACKET;

  typedef prn_t [ARCH_REG_SZ-1:0] arch_map_t;

  // Every architectural register starts out mapped to the physical register
  // with the same number.
  function automatic arch_map_t identity_map();
    arch_map_t m;
    for (int a = 0; a < ARCH_REG_SZ; a++) begin
      m[a] = prn_t'(a);
    end
    return m;
  endfunction

endpackage

// File: rtl/commit_stage_if.sv
// commit_stage_if
// Purpose: bundles the ROB-to-commit packet and every retire-side result
//          of the commit stage.
// Signals:
//   rob_ct_packet  N commit slots from the ROB
//   rob_squash     ROB mispredict flag, same cycle as the packet
//   fl_free        PRNs released to the free list
//   sq_commit_cnt  stores retired this cycle
//   bp_update      branch-predictor training slots
//   redirect_valid / redirect_pc  mispredict redirect to fetch
//   recover_map    architectural map for RAT restore
//   retired_cnt    instructions retired this cycle
//   halted/illegal sticky CPU status
// Modports: master = ROB/consumer side, slave = commit_stage.
interface commit_stage_if;
  import commit_stage_pkg::*;

  ROB_CT_PACKET           rob_ct_packet;
  logic                   rob_squash;
  CT_FL_PACKET            fl_free;
  logic [CNT_W-1:0]       sq_commit_cnt;
  CT_BP_PACKET            bp_update;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  arch_map_t              recover_map;
  logic [CNT_W-1:0]       retired_cnt;
  logic                   halted;
  logic                   illegal;

  modport master (
    output rob_ct_packet, rob_squash,
    input  fl_free, sq_commit_cnt, bp_update, redirect_valid, redirect_pc,
           recover_map, retired_cnt, halted, illegal
  );

  modport slave (
    input  rob_ct_packet, rob_squash,
    output fl_free, sq_commit_cnt, bp_update, redirect_valid, redirect_pc,
           recover_map, retired_cnt, halted, illegal
  );

endinterface

// File: rtl/commit_stage_retire_map.sv
// retire_map
// Purpose: architectural (retirement) map table. Applies up to N in-order
//          writes per cycle and returns, for each slot, the PRN that slot's
//          destination held just before it, including writes made by
//          earlier slots of the same group.
// Ports:
//   clock, reset  clock and synchronous active-high reset (map -> identity)
//   i_wr_en       per-slot write enable (already gated by group membership)
//   i_wr_arn      per-slot destination architectural register
//   i_wr_prn      per-slot new physical register
//   o_old_prn     per-slot superseded PRN
//   o_map         registered map (state after the previous group)
module retire_map
  import commit_stage_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [N-1:0]       i_wr_en,
  input  arn_t [N-1:0]       i_wr_arn,
  input  prn_t [N-1:0]       i_wr_prn,
  output prn_t [N-1:0]       o_old_prn,
  output arch_map_t          o_map
);

  arch_map_t r_map;
  arch_map_t w_next_map;

  // Walk the slots in program order over a running copy of the map. Each
  // slot looks up its old PRN before applying its own write, so a later slot
  // writing the same arn sees (and frees) the earlier slot's PRN, and the
  // later write is the one left standing.
  always_comb begin
    w_next_map = r_map;
    o_old_prn  = '0;
    for (int i = 0; i < N; i++) begin
      o_old_prn[i] = w_next_map[i_wr_arn[i]];
      if (i_wr_en[i]) begin
        w_next_map[i_wr_arn[i]] = i_wr_prn[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_map <= identity_map();
    end else begin
      r_map <= w_next_map;
    end
  end

  assign o_map = r_map;

endmodule

// File: rtl/commit_stage.sv
// commit_stage
// Purpose: in-order retire-side consumer of the ROB commit packet. Finds the
//          retiring group, updates the architectural map (via retire_map),
//          frees superseded PRNs, counts retired stores, trains the branch
//          predictor, raises the mispredict redirect with its recovery map
//          and latches halt/illegal as sticky status. All outputs are
//          registered one cycle after the packet.
// Ports:
//   clock, reset  clock and synchronous active-high reset
//   bus           commit_stage_if.slave (packet in, retire results out)
//   perf_cycles, perf_retired, perf_mispredict
//                 64-bit performance counters, present only when the
//                 COMMIT_PERF_EN macro is defined
module commit_stage
  import commit_stage_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  commit_stage_if.slave        bus
`ifdef COMMIT_PERF_EN
  ,
  output logic [63:0]          perf_cycles,
  output logic [63:0]          perf_retired,
  output logic [63:0]          perf_mispredict
`endif
);

  logic              w_stopped;
  logic [N-1:0]      w_wr_en;
  arn_t [N-1:0]      w_wr_arn;
  prn_t [N-1:0]      w_wr_prn;
  prn_t [N-1:0]      w_old_prn;
  arch_map_t         w_map;
  logic [CNT_W-1:0]  w_retired_cnt;
  logic [CNT_W-1:0]  w_sq_cnt;
  CT_BP_PACKET       w_bp;
  CT_FL_PACKET       w_fl_free;
  logic              w_misp;
  logic [31:0]       w_redirect_pc;
  logic              w_halt_hit;
  logic              w_illegal_hit;

  CT_FL_PACKET       r_fl_free;
  logic [CNT_W-1:0]  r_sq_cnt;
  CT_BP_PACKET       r_bp;
  logic              r_redirect_valid;
  logic [31:0]       r_redirect_pc;
  logic [CNT_W-1:0]  r_retired_cnt;
  logic              r_halted;
  logic              r_illegal;

  // Once halted or illegal is latched the packet is ignored until reset.
  assign w_stopped = r_halted | r_illegal;

  // Group scan: live slots form a prefix that ends at the first
  // non-executed slot, or just after a mispredict or halt slot. An illegal
  // slot also ends the group but does not itself retire. Stores and halts
  // never write the map, and arn 0 is never mapped.
  always_comb begin : scan_p
    logic     v_open;
    ROB_ENTRY v_e;
    v_open        = !w_stopped;
    v_e           = '0;
    w_wr_en       = '0;
    w_wr_arn      = '0;
    w_wr_prn      = '0;
    w_retired_cnt = '0;
    w_sq_cnt      = '0;
    w_bp          = '0;
    w_misp        = 1'b0;
    w_redirect_pc = '0;
    w_halt_hit    = 1'b0;
    w_illegal_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      v_e         = bus.rob_ct_packet.entries[i];
      w_wr_arn[i] = v_e.dest_arn;
      w_wr_prn[i] = v_e.dest_prn;
      if (v_open && v_e.executed) begin
        if (v_e.illegal) begin
          w_illegal_hit = 1'b1;
          v_open        = 1'b0;
        end else begin
          w_retired_cnt = w_retired_cnt + CNT_W'(1);
          if (v_e.halt) begin
            w_halt_hit = 1'b1;
            v_open     = 1'b0;
          end else begin
            if (v_e.is_store) begin
              w_sq_cnt = w_sq_cnt + CNT_W'(1);
            end else if (v_e.dest_arn != '0) begin
              w_wr_en[i] = 1'b1;
            end
            if (v_e.cond_branch || v_e.uncond_branch) begin
              w_bp.slot[i].valid  = 1'b1;
              w_bp.slot[i].cond   = v_e.cond_branch;
              w_bp.slot[i].taken  = v_e.resolve_taken;
              w_bp.slot[i].pc     = v_e.pc;
              w_bp.slot[i].target = v_e.resolve_target;
            end
            if (!v_e.success) begin
              w_misp        = 1'b1;
              w_redirect_pc = v_e.resolve_taken ? v_e.resolve_target : v_e.npc;
              v_open        = 1'b0;
            end
          end
        end
      end else begin
        v_open = 1'b0;
      end
    end
  end

  retire_map u_retire_map (
    .clock     (clock),
    .reset     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_arn  (w_wr_arn),
    .i_wr_prn  (w_wr_prn),
    .o_old_prn (w_old_prn),
    .o_map     (w_map)
  );

  // Every map write releases the PRN it superseded.
  always_comb begin
    w_fl_free = '0;
    for (int i = 0; i < N; i++) begin
      if (w_wr_en[i]) begin
        w_fl_free.slot[i].valid = 1'b1;
        w_fl_free.slot[i].prn   = w_old_prn[i];
      end
    end
  end

  // Per-cycle results are single-cycle pulses; status flags are sticky.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fl_free        <= '0;
      r_sq_cnt         <= '0;
      r_bp             <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_retired_cnt    <= '0;
      r_halted         <= 1'b0;
      r_illegal        <= 1'b0;
    end else begin
      r_fl_free        <= w_fl_free;
      r_sq_cnt         <= w_sq_cnt;
      r_bp             <= w_bp;
      r_redirect_valid <= w_misp;
      r_redirect_pc    <= w_redirect_pc;
      r_retired_cnt    <= w_retired_cnt;
      r_halted         <= r_halted | w_halt_hit;
      r_illegal        <= r_illegal | w_illegal_hit;
    end
  end

  assign bus.fl_free        = r_fl_free;
  assign bus.sq_commit_cnt  = r_sq_cnt;
  assign bus.bp_update      = r_bp;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.recover_map    = w_map;
  assign bus.retired_cnt    = r_retired_cnt;
  assign bus.halted         = r_halted;
  assign bus.illegal        = r_illegal;

  // A squash from the ROB must coincide with a retiring mispredicted slot.
  a_squash_has_misp: assert property (
    @(posedge clock) disable iff (reset)
      (bus.rob_squash && !w_stopped) |-> w_misp
  );

`ifdef COMMIT_PERF_EN
  logic [63:0] r_perf_cycles;
  logic [63:0] r_perf_retired;
  logic [63:0] r_perf_mispredict;

  // Counters freeze once the core has halted.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_cycles     <= '0;
      r_perf_retired    <= '0;
      r_perf_mispredict <= '0;
    end else if (!r_halted) begin
      r_perf_cycles     <= r_perf_cycles + 64'd1;
      r_perf_retired    <= r_perf_retired + 64'(w_retired_cnt);
      r_perf_mispredict <= r_perf_mispredict + 64'(w_misp);
    end
  end

  assign perf_cycles     = r_perf_cycles;
  assign perf_retired    = r_perf_retired;
  assign perf_mispredict = r_perf_mispredict;
`endif

endmodule

// File: tb/tb_commit_stage.sv
// tb_commit_stage
// Purpose: directed self-checking bench for commit_stage. Drives commit
//          packets through the interface and compares registered results
//          against hand-computed values. The perf counter step is built
//          only when COMMIT_PERF_EN is defined.
module tb_commit_stage;
  import commit_stage_pkg::*;

  logic clock;
  logic reset;
  int   testsRun;
  int   failCount;

  commit_stage_if bus ();

`ifdef COMMIT_PERF_EN
  logic [63:0] perfCycles;
  logic [63:0] perfRetired;
  logic [63:0] perfMispredict;
`endif

  commit_stage dut (
    .clock           (clock),
    .reset           (reset),
    .bus             (bus.slave)
`ifdef COMMIT_PERF_EN
    ,
    .perf_cycles     (perfCycles),
    .perf_retired    (perfRetired),
    .perf_mispredict (perfMispredict)
`endif
  );

  // Free-running 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // An executed, successful ALU-style slot writing arn with prn.
  function automatic ROB_ENTRY mkEntry(input int arn, input int prn);
    ROB_ENTRY e;
    e          = '0;
    e.executed = 1'b1;
    e.success  = 1'b1;
    e.dest_arn = arn_t'(arn);
    e.dest_prn = prn_t'(prn);
    return e;
  endfunction

  // Clock the current packet in, then return the inputs to idle; results
  // are sampled 1 ns after the edge.
  task automatic applyStimulus();
    @(posedge clock);
    #1;
    bus.rob_ct_packet = '0;
    bus.rob_squash    = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    bus.rob_ct_packet = '0;
    bus.rob_squash    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    ROB_ENTRY e;
    testsRun  = 0;
    failCount = 0;
    reset     = 1'b0;

    // Reset state
    doReset();
    checkOutput("reset_map5",     64'(bus.recover_map[5]), 64'd5);
    checkOutput("reset_retired",  64'(bus.retired_cnt),    64'd0);
    checkOutput("reset_sq",       64'(bus.sq_commit_cnt),  64'd0);
    checkOutput("reset_halted",   64'(bus.halted),         64'd0);
    checkOutput("reset_illegal",  64'(bus.illegal),        64'd0);
    checkOutput("reset_redirect", 64'(bus.redirect_valid), 64'd0);
    checkOutput("reset_fl0",      64'(bus.fl_free.slot[0]), 64'd0);

    // Two independent writers: old PRNs come from the identity map
    bus.rob_ct_packet.entries[0] = mkEntry(3, 40);
    bus.rob_ct_packet.entries[1] = mkEntry(4, 41);
    applyStimulus();
    checkOutput("two_fl0",     64'(bus.fl_free.slot[0]), 64'({1'b1, prn_t'(3)}));
    checkOutput("two_fl1",     64'(bus.fl_free.slot[1]), 64'({1'b1, prn_t'(4)}));
    checkOutput("two_fl2",     64'(bus.fl_free.slot[2]), 64'd0);
    checkOutput("two_retired", 64'(bus.retired_cnt),     64'd2);
    checkOutput("two_map3",    64'(bus.recover_map[3]),  64'd40);
    checkOutput("two_map4",    64'(bus.recover_map[4]),  64'd41);

    // Same arn twice in one group: second frees the first's PRN
    bus.rob_ct_packet.entries[0] = mkEntry(7, 50);
    bus.rob_ct_packet.entries[1] = mkEntry(7, 51);
    applyStimulus();
    checkOutput("dup_fl0",  64'(bus.fl_free.slot[0]), 64'({1'b1, prn_t'(7)}));
    checkOutput("dup_fl1",  64'(bus.fl_free.slot[1]), 64'({1'b1, prn_t'(50)}));
    checkOutput("dup_map7", 64'(bus.recover_map[7]),  64'd51);

    // ALU, then taken mispredicted branch, then an ALU that must be dropped
    bus.rob_ct_packet.entries[0] = mkEntry(10, 61);
    e = mkEntry(0, 0);
    e.cond_branch    = 1'b1;
    e.success        = 1'b0;
    e.resolve_taken  = 1'b1;
    e.resolve_target = 32'h200;
    e.pc             = 32'h100;
    e.npc            = 32'h104;
    bus.rob_ct_packet.entries[1] = e;
    bus.rob_ct_packet.entries[2] = mkEntry(11, 62);
    bus.rob_squash = 1'b1;
    applyStimulus();
    checkOutput("misp_redirect", 64'(bus.redirect_valid),        64'd1);
    checkOutput("misp_pc",       64'(bus.redirect_pc),           64'h200);
    checkOutput("misp_bp1_val",  64'(bus.bp_update.slot[1].valid), 64'd1);
    checkOutput("misp_bp1_tkn",  64'(bus.bp_update.slot[1].taken), 64'd1);
    checkOutput("misp_bp1_tgt",  64'(bus.bp_update.slot[1].target), 64'h200);
    checkOutput("misp_bp0_val",  64'(bus.bp_update.slot[0].valid), 64'd0);
    checkOutput("misp_retired",  64'(bus.retired_cnt),           64'd2);
    checkOutput("misp_map10",    64'(bus.recover_map[10]),       64'd61);
    checkOutput("misp_map11",    64'(bus.recover_map[11]),       64'd11);

    // Not-taken mispredict redirects to the fall-through PC
    e = mkEntry(0, 0);
    e.cond_branch    = 1'b1;
    e.success        = 1'b0;
    e.resolve_taken  = 1'b0;
    e.resolve_target = 32'h300;
    e.npc            = 32'h104;
    bus.rob_ct_packet.entries[0] = e;
    bus.rob_squash = 1'b1;
    applyStimulus();
    checkOutput("nt_redirect", 64'(bus.redirect_valid), 64'd1);
    checkOutput("nt_pc",       64'(bus.redirect_pc),    64'h104);

    // Slot0 not executed: nothing retires and the pulses clear
    e = mkEntry(9, 60);
    e.executed = 1'b0;
    bus.rob_ct_packet.entries[0] = e;
    bus.rob_ct_packet.entries[1] = mkEntry(9, 60);
    applyStimulus();
    checkOutput("hole_retired",  64'(bus.retired_cnt),      64'd0);
    checkOutput("hole_fl1",      64'(bus.fl_free.slot[1]),  64'd0);
    checkOutput("hole_map9",     64'(bus.recover_map[9]),   64'd9);
    checkOutput("hole_redirect", 64'(bus.redirect_valid),   64'd0);
    checkOutput("hole_bp",       64'(bus.bp_update.slot[0].valid), 64'd0);

    // Store, halt, ALU: halt ends the group
    e = mkEntry(0, 0);
    e.is_store = 1'b1;
    bus.rob_ct_packet.entries[0] = e;
    e = mkEntry(0, 0);
    e.halt = 1'b1;
    bus.rob_ct_packet.entries[1] = e;
    bus.rob_ct_packet.entries[2] = mkEntry(12, 63);
    applyStimulus();
    checkOutput("halt_sq",      64'(bus.sq_commit_cnt),    64'd1);
    checkOutput("halt_retired", 64'(bus.retired_cnt),      64'd2);
    checkOutput("halt_flag",    64'(bus.halted),           64'd1);
    checkOutput("halt_map12",   64'(bus.recover_map[12]),  64'd12);
    checkOutput("halt_fl0",     64'(bus.fl_free.slot[0]),  64'd0);

    // After halt, packets are ignored
    bus.rob_ct_packet.entries[0] = mkEntry(13, 33);
    applyStimulus();
    checkOutput("post_halt_retired", 64'(bus.retired_cnt),     64'd0);
    checkOutput("post_halt_map13",   64'(bus.recover_map[13]), 64'd13);
    checkOutput("post_halt_flag",    64'(bus.halted),          64'd1);

    // Reset clears status and restores the identity map
    doReset();
    checkOutput("rst2_halted", 64'(bus.halted),         64'd0);
    checkOutput("rst2_map3",   64'(bus.recover_map[3]), 64'd3);

    // Illegal slot ends the group without retiring
    bus.rob_ct_packet.entries[0] = mkEntry(14, 20);
    e = mkEntry(0, 0);
    e.illegal = 1'b1;
    bus.rob_ct_packet.entries[1] = e;
    bus.rob_ct_packet.entries[2] = mkEntry(15, 21);
    applyStimulus();
    checkOutput("ill_retired", 64'(bus.retired_cnt),     64'd1);
    checkOutput("ill_flag",    64'(bus.illegal),         64'd1);
    checkOutput("ill_map14",   64'(bus.recover_map[14]), 64'd20);
    checkOutput("ill_map15",   64'(bus.recover_map[15]), 64'd15);
    checkOutput("ill_fl2",     64'(bus.fl_free.slot[2]), 64'd0);

`ifdef COMMIT_PERF_EN
    // Ten counted cycles: one group with three retirements and a mispredict
    doReset();
    bus.rob_ct_packet.entries[0] = mkEntry(3, 40);
    bus.rob_ct_packet.entries[1] = mkEntry(4, 41);
    e = mkEntry(0, 0);
    e.cond_branch    = 1'b1;
    e.success        = 1'b0;
    e.resolve_taken  = 1'b1;
    e.resolve_target = 32'h400;
    bus.rob_ct_packet.entries[2] = e;
    bus.rob_squash = 1'b1;
    applyStimulus();
    repeat (9) @(posedge clock);
    #1;
    checkOutput("perf_cycles",     perfCycles,     64'd10);
    checkOutput("perf_retired",    perfRetired,    64'd3);
    checkOutput("perf_mispredict", perfMispredict, 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
